// File: rtl/branch_resolve_bht_pkg.sv
// Shared branch-type codes and helpers for the EX-stage branch resolver and its BHT.
// The codes match the core's Parameters.v encoding bit for bit.
package branch_resolve_bht_pkg;

  localparam logic [2:0] BT_NOBRANCH = 3'd0;
  localparam logic [2:0] BT_BEQ      = 3'd1;
  localparam logic [2:0] BT_BNE      = 3'd2;
  localparam logic [2:0] BT_BLT      = 3'd3;
  localparam logic [2:0] BT_BLTU     = 3'd4;
  localparam logic [2:0] BT_BGE      = 3'd5;
  localparam logic [2:0] BT_BGEU     = 3'd6;

  // Codes 0 and 7 are not conditional branches.
  function automatic logic is_cond_branch(input logic [2:0] bt);
    return (bt >= BT_BEQ) && (bt <= BT_BGEU);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// One BHT entry: a saturating up/down counter.
// It resets to weakly-not-taken, which is 0 followed by all ones.
module sat_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] INIT = WIDTH'((1 << (WIDTH-1)) - 1);
  localparam logic [WIDTH-1:0] MAX  = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= INIT;
    end else if (en) begin
      if (up) begin
        if (value != MAX) value <= value + 1'b1;
      end else if (value != '0) begin
        value <= value - 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// Top level: EX-stage branch resolution, an IF-stage BHT lookup and mispredict flagging.
// It also keeps saturating counts of branches and mispredicts.
module branch_resolve_bht
  import branch_resolve_bht_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int STAT_BITS   = 32
) (
  input  logic                 CPU_CLK,
  input  logic                 CPU_RST,
  input  logic [XLEN-1:0]      lookup_pc,
  output logic                 pred_taken,
  input  logic                 resolve_valid,
  input  logic [XLEN-1:0]      resolve_pc,
  input  logic [2:0]           BranchTypeE,
  input  logic [XLEN-1:0]      Operand1,
  input  logic [XLEN-1:0]      Operand2,
  input  logic                 pred_taken_e,
  output logic                 Branch,
  output logic                 mispredict,
  input  logic                 stat_clear,
  output logic [STAT_BITS-1:0] stat_branches,
  output logic [STAT_BITS-1:0] stat_mispredicts
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [IDX-1:0] lkp_idx, res_idx;
  logic           taken, is_br;
  logic [BHT_ENTRIES-1:0][CTR_BITS-1:0] ctr;

  assign lkp_idx = lookup_pc[IDX+1:2];
  assign res_idx = resolve_pc[IDX+1:2];

  // The PC's upper bits alias freely, and its low two bits are ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[XLEN-1:IDX+2], lookup_pc[1:0],
                            resolve_pc[XLEN-1:IDX+2], resolve_pc[1:0]};

  always_comb begin
    taken = 1'b0;
    case (BranchTypeE)
      BT_BEQ:  taken = (Operand1 == Operand2);
      BT_BNE:  taken = (Operand1 != Operand2);
      BT_BLT:  taken = ($signed(Operand1) <  $signed(Operand2));
      BT_BGE:  taken = ($signed(Operand1) >= $signed(Operand2));
      BT_BLTU: taken = (Operand1 <  Operand2);
      BT_BGEU: taken = (Operand1 >= Operand2);
      default: taken = 1'b0;
    endcase
  end

  assign is_br      = resolve_valid && is_cond_branch(BranchTypeE);
  assign Branch     = resolve_valid && taken;
  assign mispredict = is_br && (Branch ^ pred_taken_e);

  // The lookup reads the pre-edge state, so an update to the same index shows up a cycle later.
  assign pred_taken = ctr[lkp_idx][CTR_BITS-1];

  genvar i;
  generate
    for (i = 0; i < BHT_ENTRIES; i++) begin : g_bht
      sat_counter #(.WIDTH(CTR_BITS)) u_ctr (
        .clk   (CPU_CLK),
        .rst   (CPU_RST),
        .en    (is_br && (res_idx == IDX'(i))),
        .up    (Branch),
        .value (ctr[i])
      );
    end
  endgenerate

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clear) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (is_br && (stat_branches != '1))
        stat_branches <= stat_branches + 1'b1;
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed self-checking bench for branch_resolve_bht at its default parameters.
// Inputs change on the falling edge; checks run 1 ns later.
module tb_branch_resolve_bht;

  localparam logic [2:0] NOB  = 3'd0;
  localparam logic [2:0] BEQ  = 3'd1;
  localparam logic [2:0] BNE  = 3'd2;
  localparam logic [2:0] BLT  = 3'd3;
  localparam logic [2:0] BLTU = 3'd4;
  localparam logic [2:0] BGE  = 3'd5;
  localparam logic [2:0] BGEU = 3'd6;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_taken;
  logic        resolve_valid = 1'b0;
  logic [31:0] resolve_pc = '0;
  logic [2:0]  BranchTypeE = '0;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic        pred_taken_e = 1'b0;
  logic        Branch;
  logic        mispredict;
  logic        stat_clear = 1'b0;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checks = 0;
  int errors = 0;

  branch_resolve_bht dut (
    .CPU_CLK         (CPU_CLK),
    .CPU_RST         (CPU_RST),
    .lookup_pc       (lookup_pc),
    .pred_taken      (pred_taken),
    .resolve_valid   (resolve_valid),
    .resolve_pc      (resolve_pc),
    .BranchTypeE     (BranchTypeE),
    .Operand1        (Operand1),
    .Operand2        (Operand2),
    .pred_taken_e    (pred_taken_e),
    .Branch          (Branch),
    .mispredict      (mispredict),
    .stat_clear      (stat_clear),
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  task automatic drv(input logic v, input logic [31:0] pc, input logic [2:0] bt,
                     input logic [31:0] a, input logic [31:0] b, input logic pe);
    resolve_valid = v; resolve_pc = pc; BranchTypeE = bt;
    Operand1 = a; Operand2 = b; pred_taken_e = pe;
  endtask

  task automatic do_reset();
    @(negedge CPU_CLK);
    CPU_RST = 1'b1; stat_clear = 1'b0;
    drv(1'b0, 32'h0, NOB, 32'h0, 32'h0, 1'b0);
    @(negedge CPU_CLK);
    CPU_RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    lookup_pc = 32'h0000_0040;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got %b exp 0", pred_taken); end
    checks++; if (stat_branches !== 32'd0) begin errors++; $display("FAIL reset_branches got %0d exp 0", stat_branches); end
    checks++; if (stat_mispredicts !== 32'd0) begin errors++; $display("FAIL reset_mispredicts got %0d exp 0", stat_mispredicts); end
    checks++; if (dut.ctr[16] !== 2'b01) begin errors++; $display("FAIL reset_ctr got %b exp 01", dut.ctr[16]); end
  endtask

  task automatic test_compare();
    logic [2:0]  bt [8]  = '{BLT, BLTU, BGE, BGEU, BEQ, BNE, NOB, 3'd7};
    logic [31:0] a  [8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                             32'h1234_5678, 32'h1234_5678, 32'h5, 32'h5};
    logic [31:0] b  [8]  = '{32'h1, 32'h1, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                             32'h1234_5679, 32'h1234_5679, 32'h5, 32'h5};
    logic        exp_br [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        exp_mp [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      @(negedge CPU_CLK);
      drv(1'b1, 32'h3C, bt[k], a[k], b[k], 1'b0);
      #1;
      checks++; if (Branch !== exp_br[k]) begin errors++; $display("FAIL cmp_branch[%0d] got %b exp %b", k, Branch, exp_br[k]); end
      checks++; if (mispredict !== exp_mp[k]) begin errors++; $display("FAIL cmp_mispredict[%0d] got %b exp %b", k, mispredict, exp_mp[k]); end
    end
  endtask

  task automatic test_training();
    logic [1:0] exp_ctr [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
    do_reset();
    lookup_pc = 32'h100;
    drv(1'b1, 32'h100, BEQ, 32'h5, 32'h5, 1'b0);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL train_mispredict got %b exp 1", mispredict); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL train_pred_before got %b exp 0", pred_taken); end
    @(negedge CPU_CLK);
    drv(1'b0, 32'h0, NOB, 32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_pred_after got %b exp 1", pred_taken); end
    @(negedge CPU_CLK);
    drv(1'b1, 32'h100, BEQ, 32'h7, 32'h7, 1'b1);
    #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL train_correct got %b exp 0", mispredict); end
    @(negedge CPU_CLK);
    drv(1'b0, 32'h0, NOB, 32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (dut.ctr[0] !== 2'b11) begin errors++; $display("FAIL train_ctr_sat_hi got %b exp 11", dut.ctr[0]); end
    for (int k = 0; k < 4; k++) begin
      @(negedge CPU_CLK);
      drv(1'b1, 32'h100, BEQ, 32'h1, 32'h2, 1'b0);
      #1;
      checks++; if (pred_taken !== (k < 2)) begin errors++; $display("FAIL train_nt_pred[%0d] got %b exp %b", k, pred_taken, (k < 2)); end
      @(negedge CPU_CLK);
      drv(1'b0, 32'h0, NOB, 32'h0, 32'h0, 1'b0);
      #1;
      checks++; if (dut.ctr[0] !== exp_ctr[k]) begin errors++; $display("FAIL train_nt_ctr[%0d] got %b exp %b", k, dut.ctr[0], exp_ctr[k]); end
    end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL train_final_pred got %b exp 0", pred_taken); end
  endtask

  // Counter at index 0 sits at 00 from the training test.
  task automatic test_same_cycle();
    @(negedge CPU_CLK);
    lookup_pc = 32'h100;
    drv(1'b1, 32'h100, BEQ, 32'h3, 32'h3, 1'b0);
    @(negedge CPU_CLK);
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL same_old_pred got %b exp 0", pred_taken); end
    @(negedge CPU_CLK);
    drv(1'b0, 32'h0, NOB, 32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL same_new_pred got %b exp 1", pred_taken); end
  endtask

  task automatic test_alias();
    do_reset();
    drv(1'b1, 32'h100, BEQ, 32'h9, 32'h9, 1'b0);
    @(negedge CPU_CLK);
    drv(1'b0, 32'h0, NOB, 32'h0, 32'h0, 1'b0);
    lookup_pc = 32'h200;
    #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_200 got %b exp 1", pred_taken); end
    lookup_pc = 32'h104;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_104 got %b exp 0", pred_taken); end
  endtask

  task automatic test_stats();
    do_reset();
    drv(1'b1, 32'h10, BEQ,  32'h4, 32'h4, 1'b1); @(negedge CPU_CLK);
    drv(1'b1, 32'h14, NOB,  32'h4, 32'h4, 1'b0); @(negedge CPU_CLK);
    drv(1'b1, 32'h18, BNE,  32'h4, 32'h4, 1'b0); @(negedge CPU_CLK);
    drv(1'b1, 32'h1C, BLT,  32'h1, 32'h2, 1'b0); @(negedge CPU_CLK);
    drv(1'b0, 32'h20, BEQ,  32'h4, 32'h4, 1'b0); @(negedge CPU_CLK);
    drv(1'b1, 32'h24, BGEU, 32'h1, 32'h2, 1'b1); @(negedge CPU_CLK);
    drv(1'b1, 32'h28, BLTU, 32'h1, 32'h2, 1'b1); @(negedge CPU_CLK);
    drv(1'b0, 32'h100, BEQ, 32'h9, 32'h9, 1'b0);
    #1;
    checks++; if (stat_branches !== 32'd5) begin errors++; $display("FAIL stat_branches got %0d exp 5", stat_branches); end
    checks++; if (stat_mispredicts !== 32'd2) begin errors++; $display("FAIL stat_mispredicts got %0d exp 2", stat_mispredicts); end
    checks++; if (Branch !== 1'b0) begin errors++; $display("FAIL invalid_branch got %b exp 0", Branch); end
    @(negedge CPU_CLK);
    #1;
    checks++; if (stat_branches !== 32'd5) begin errors++; $display("FAIL invalid_no_count got %0d exp 5", stat_branches); end
    stat_clear = 1'b1;
    drv(1'b1, 32'h100, BEQ, 32'h9, 32'h9, 1'b0);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL clear_mispredict got %b exp 1", mispredict); end
    @(negedge CPU_CLK);
    stat_clear = 1'b0;
    drv(1'b0, 32'h0, NOB, 32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (stat_branches !== 32'd0) begin errors++; $display("FAIL clear_branches got %0d exp 0", stat_branches); end
    checks++; if (stat_mispredicts !== 32'd0) begin errors++; $display("FAIL clear_mispredicts got %0d exp 0", stat_mispredicts); end
  endtask

  task automatic test_reset_mid();
    lookup_pc = 32'h100;
    @(negedge CPU_CLK);
    drv(1'b1, 32'h100, BEQ, 32'h1, 32'h1, 1'b0); @(negedge CPU_CLK);
    drv(1'b1, 32'h100, BEQ, 32'h1, 32'h1, 1'b0); @(negedge CPU_CLK);
    drv(1'b0, 32'h0, NOB, 32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (stat_branches !== 32'd2) begin errors++; $display("FAIL mid_pre_branches got %0d exp 2", stat_branches); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL mid_pre_pred got %b exp 1", pred_taken); end
    @(negedge CPU_CLK);
    drv(1'b1, 32'h100, BEQ, 32'h1, 32'h1, 1'b0);
    CPU_RST = 1'b1;
    #1;
    checks++; if (stat_branches !== 32'd0) begin errors++; $display("FAIL mid_async_branches got %0d exp 0", stat_branches); end
    checks++; if (stat_mispredicts !== 32'd0) begin errors++; $display("FAIL mid_async_mispredicts got %0d exp 0", stat_mispredicts); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL mid_async_pred got %b exp 0", pred_taken); end
    @(negedge CPU_CLK);
    #1;
    checks++; if (stat_branches !== 32'd0) begin errors++; $display("FAIL mid_held_branches got %0d exp 0", stat_branches); end
    checks++; if (dut.ctr[0] !== 2'b01) begin errors++; $display("FAIL mid_held_ctr got %b exp 01", dut.ctr[0]); end
    CPU_RST = 1'b0;
    drv(1'b0, 32'h0, NOB, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_compare();
    test_training();
    test_same_cycle();
    test_alias();
    test_stats();
    test_reset_mid();
    @(negedge CPU_CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
